// File: rtl/decode_stage_pipe.sv
// RV32 instruction-decode stage: architectural register file with optional
// write-to-read bypass, immediate extension, and the ID/EX pipeline register.

module decode_rd_port #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1
) (
    input  logic [NREGS-1:0][XLEN-1:0] regs,
    input  logic                       wr_ok,
    input  logic [4:0]                 wr_addr,
    input  logic [XLEN-1:0]            wr_data,
    input  logic [4:0]                 idx,
    output logic [XLEN-1:0]            data
);
    localparam int AW = $clog2(NREGS);

    // Out-of-range indices read as zero; x0 is never written so regs[0] stays zero.
    always_comb begin
        data = '0;
        if (int'(idx) < NREGS) begin
            if ((BYPASS != 0) && wr_ok && (wr_addr == idx))
                data = wr_data;
            else
                data = regs[idx[AW-1:0]];
        end
    end
endmodule

module decode_stage_pipe #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_d_valid,
    input  logic [31:0]     i_d_instr,
    input  logic [XLEN-1:0] i_d_pc,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic            i_en_regfile_write,
    input  logic [4:0]      i_result_addr,
    input  logic [XLEN-1:0] i_final_result,
    input  logic [2:0]      i_mux_immext_src,
    output logic            o_e_valid,
    output logic [XLEN-1:0] o_e_rd1,
    output logic [XLEN-1:0] o_e_rd2,
    output logic [XLEN-1:0] o_e_immext,
    output logic [XLEN-1:0] o_e_pc,
    output logic [4:0]      o_e_rs1,
    output logic [4:0]      o_e_rs2,
    output logic [4:0]      o_e_rd,
    output logic            o_e_illegal
);
    localparam int AW = $clog2(NREGS);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            illegal;
    } idex_t;

    logic [4:0] rs1, rs2, rd;
    assign rs1 = i_d_instr[19:15];
    assign rs2 = i_d_instr[24:20];
    assign rd  = i_d_instr[11:7];

    logic unused_opcode;
    assign unused_opcode = ^i_d_instr[6:0];

    // A writeback is architecturally real only for x1..x(NREGS-1).
    logic wr_ok;
    assign wr_ok = i_en_regfile_write && (i_result_addr != 5'd0) &&
                   (int'(i_result_addr) < NREGS);

    logic [NREGS-1:0][XLEN-1:0] regs;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            regs <= '0;
        else if (wr_ok)
            regs[i_result_addr[AW-1:0]] <= i_final_result;
    end

    logic [1:0][4:0]      rs_idx;
    logic [1:0][XLEN-1:0] rd_val;
    assign rs_idx = {rs2, rs1};

    for (genvar p = 0; p < 2; p++) begin : g_rd
        decode_rd_port #(
            .XLEN  (XLEN),
            .NREGS (NREGS),
            .BYPASS(BYPASS)
        ) u_port (
            .regs   (regs),
            .wr_ok  (wr_ok),
            .wr_addr(i_result_addr),
            .wr_data(i_final_result),
            .idx    (rs_idx[p]),
            .data   (rd_val[p])
        );
    end

    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_ext;

    always_comb begin
        imm32 = '0;
        case (i_mux_immext_src)
            3'b000:  imm32 = {{20{i_d_instr[31]}}, i_d_instr[31:20]};
            3'b001:  imm32 = {{20{i_d_instr[31]}}, i_d_instr[31:25], i_d_instr[11:7]};
            3'b010:  imm32 = {{20{i_d_instr[31]}}, i_d_instr[7], i_d_instr[30:25],
                              i_d_instr[11:8], 1'b0};
            3'b011:  imm32 = {{12{i_d_instr[31]}}, i_d_instr[19:12], i_d_instr[20],
                              i_d_instr[30:21], 1'b0};
            3'b100:  imm32 = {i_d_instr[31:12], 12'b0};
            default: imm32 = '0;
        endcase
    end

    // U-type is sign-extended too when XLEN=64.
    assign imm_ext = XLEN'($signed(imm32));

    logic illegal;
    assign illegal = (NREGS < 32) && i_d_valid &&
                     ((int'(rs1) >= NREGS) || (int'(rs2) >= NREGS) || (int'(rd) >= NREGS));

    idex_t q, d;

    always_comb begin
        d = q;
        if (i_flush) begin
            d = '0;
        end else if (i_stall) begin
            // Keep held operands fresh while the slot waits out a long stall.
            if (q.valid && wr_ok && (q.rs1 == i_result_addr)) d.rd1 = i_final_result;
            if (q.valid && wr_ok && (q.rs2 == i_result_addr)) d.rd2 = i_final_result;
        end else begin
            d.valid   = i_d_valid;
            d.rd1     = rd_val[0];
            d.rd2     = rd_val[1];
            d.imm     = imm_ext;
            d.pc      = i_d_pc;
            d.rs1     = rs1;
            d.rs2     = rs2;
            d.rd      = rd;
            d.illegal = illegal;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            q <= '0;
        else
            q <= d;
    end

    assign o_e_valid   = q.valid;
    assign o_e_rd1     = q.rd1;
    assign o_e_rd2     = q.rd2;
    assign o_e_immext  = q.imm;
    assign o_e_pc      = q.pc;
    assign o_e_rs1     = q.rs1;
    assign o_e_rs2     = q.rs2;
    assign o_e_rd      = q.rd;
    assign o_e_illegal = q.illegal;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: bypass, no-bypass and RV32E/XLEN=64 instances
// share one stimulus stream; the bypass instance is scoreboarded every cycle.

module tb_decode_stage_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        d_valid, stall, flush, we;
    logic [31:0] instr, pc, wdata;
    logic [4:0]  waddr;
    logic [2:0]  src;
    logic [63:0] pc64, wdata64;

    always #5 clk = ~clk;
    assign pc64    = {32'h0, pc};
    assign wdata64 = {32'h0, wdata};

    logic        b_valid, b_ill, n_valid, n_ill, w_valid, w_ill;
    logic [31:0] b_rd1, b_rd2, b_imm, b_pc, n_rd1, n_rd2, n_imm, n_pc;
    logic [63:0] w_rd1, w_rd2, w_imm, w_pc;
    logic [4:0]  b_rs1, b_rs2, b_rd, n_rs1, n_rs2, n_rd, w_rs1, w_rs2, w_rd;

    decode_stage_pipe #(.XLEN(32), .NREGS(32), .BYPASS(1)) u_b (
        .i_clk(clk), .i_rst(rst), .i_d_valid(d_valid), .i_d_instr(instr), .i_d_pc(pc),
        .i_stall(stall), .i_flush(flush), .i_en_regfile_write(we), .i_result_addr(waddr),
        .i_final_result(wdata), .i_mux_immext_src(src), .o_e_valid(b_valid),
        .o_e_rd1(b_rd1), .o_e_rd2(b_rd2), .o_e_immext(b_imm), .o_e_pc(b_pc),
        .o_e_rs1(b_rs1), .o_e_rs2(b_rs2), .o_e_rd(b_rd), .o_e_illegal(b_ill));

    decode_stage_pipe #(.XLEN(32), .NREGS(32), .BYPASS(0)) u_n (
        .i_clk(clk), .i_rst(rst), .i_d_valid(d_valid), .i_d_instr(instr), .i_d_pc(pc),
        .i_stall(stall), .i_flush(flush), .i_en_regfile_write(we), .i_result_addr(waddr),
        .i_final_result(wdata), .i_mux_immext_src(src), .o_e_valid(n_valid),
        .o_e_rd1(n_rd1), .o_e_rd2(n_rd2), .o_e_immext(n_imm), .o_e_pc(n_pc),
        .o_e_rs1(n_rs1), .o_e_rs2(n_rs2), .o_e_rd(n_rd), .o_e_illegal(n_ill));

    decode_stage_pipe #(.XLEN(64), .NREGS(16), .BYPASS(1)) u_w (
        .i_clk(clk), .i_rst(rst), .i_d_valid(d_valid), .i_d_instr(instr), .i_d_pc(pc64),
        .i_stall(stall), .i_flush(flush), .i_en_regfile_write(we), .i_result_addr(waddr),
        .i_final_result(wdata64), .i_mux_immext_src(src), .o_e_valid(w_valid),
        .o_e_rd1(w_rd1), .o_e_rd2(w_rd2), .o_e_immext(w_imm), .o_e_pc(w_pc),
        .o_e_rs1(w_rs1), .o_e_rs2(w_rs2), .o_e_rd(w_rd), .o_e_illegal(w_ill));

    typedef struct packed {
        logic        valid;
        logic [31:0] rd1, rd2, imm, pc;
        logic [4:0]  rs1, rs2, rd;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  src;
        logic        valid;
        logic [31:0] imm;
    } vec_t;

    exp_t        sb[$];
    exp_t        cur;
    logic [31:0] rf[32];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_r(input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [4:0] rd);
        return {7'h0, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction

    function automatic logic [31:0] rdv(input logic [4:0] i);
        if (i == 5'd0) return 32'h0;
        if (we && waddr == i) return wdata;
        return rf[i];
    endfunction

    task automatic idle();
        d_valid = 0; instr = 0; pc = 0; stall = 0; flush = 0;
        we = 0; waddr = 0; wdata = 0; src = 0;
    endtask

    // One clock: predict the bypass instance, push, clock, pop and compare.
    task automatic step(input logic [31:0] exp_imm);
        exp_t nxt, e;
        logic wok;
        wok = we && (waddr != 5'd0);
        nxt = cur;
        if (flush) begin
            nxt = '0;
        end else if (stall) begin
            if (cur.valid && wok && cur.rs1 == waddr) nxt.rd1 = wdata;
            if (cur.valid && wok && cur.rs2 == waddr) nxt.rd2 = wdata;
        end else begin
            nxt.valid = d_valid;
            nxt.rd1   = rdv(instr[19:15]);
            nxt.rd2   = rdv(instr[24:20]);
            nxt.imm   = exp_imm;
            nxt.pc    = pc;
            nxt.rs1   = instr[19:15];
            nxt.rs2   = instr[24:20];
            nxt.rd    = instr[11:7];
            nxt.ill   = 1'b0;
        end
        sb.push_back(nxt);
        @(posedge clk);
        if (wok) rf[waddr] = wdata;
        cur = nxt;
        #1;
        e = sb.pop_front();
        chk("valid", b_valid, e.valid);
        chk("rd1", b_rd1, e.rd1);
        chk("rd2", b_rd2, e.rd2);
        chk("immext", b_imm, e.imm);
        chk("pc", b_pc, e.pc);
        chk("rs1", b_rs1, e.rs1);
        chk("rs2", b_rs2, e.rs2);
        chk("rd", b_rd, e.rd);
        chk("illegal", b_ill, e.ill);
    endtask

    task automatic hit_reset();
        rst = 1'b1;
        #1;
        chk("rst_valid", b_valid, 0);
        chk("rst_rd1", b_rd1, 0);
        chk("rst_rd2", b_rd2, 0);
        chk("rst_imm", b_imm, 0);
        chk("rst_pc", b_pc, 0);
        chk("rst_idx", {b_rs1, b_rs2, b_rd, b_ill}, 0);
        chk("rst_n_valid", n_valid, 0);
        chk("rst_w_fields", w_rd1 | w_imm | w_pc, 0);
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        cur = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        vecs[0] = '{32'hFFF00093, 3'b000, 1'b1, 32'hFFFFFFFF};
        vecs[1] = '{32'h7FF00093, 3'b000, 1'b1, 32'h000007FF};
        vecs[2] = '{32'h00A12423, 3'b001, 1'b1, 32'h00000008};
        vecs[3] = '{32'hFE112E23, 3'b001, 1'b1, 32'hFFFFFFFC};
        vecs[4] = '{32'hFE000EE3, 3'b010, 1'b1, 32'hFFFFFFFC};
        vecs[5] = '{32'h008000EF, 3'b011, 1'b1, 32'h00000008};
        vecs[6] = '{32'hFFDFF06F, 3'b011, 1'b1, 32'hFFFFFFFC};
        vecs[7] = '{32'h123450B7, 3'b100, 1'b1, 32'h12345000};
        vecs[8] = '{32'hFFFFFFFF, 3'b101, 1'b1, 32'h00000000};
        vecs[9] = '{32'hFFFFFFFF, 3'b111, 1'b0, 32'h00000000};

        idle();
        hit_reset();

        // RV32E/XLEN=64 instance: out-of-range index flags and dropped writes.
        instr = mk_r(5'd17, 5'd0, 5'd1); d_valid = 1; pc = 32'h100;
        step(32'h0);
        chk("w_illegal_rs17", w_ill, 1);
        chk("w_rd1_rs17", w_rd1, 0);
        instr = mk_r(5'd4, 5'd20, 5'd0); we = 1; waddr = 5'd20; wdata = 32'hCAFE0001;
        step(32'd20);
        chk("w_rd2_x20", w_rd2, 0);
        we = 0; instr = mk_r(5'd4, 5'd4, 5'd0);
        step(32'd4);
        chk("w_x4_untouched", w_rd1, 0);
        chk("w_illegal_clear", w_ill, 0);
        instr = 32'h80000037; src = 3'b100;
        step(32'h80000000);
        chk("w_u_imm64", w_imm, 64'hFFFFFFFF80000000);

        // Same-cycle writeback and decode of x5.
        src = 0; instr = mk_r(5'd5, 5'd0, 5'd2); we = 1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        step(32'h0);
        chk("b_bypass_rd1", b_rd1, 32'hDEADBEEF);
        chk("n_nobypass_rd1", n_rd1, 0);
        we = 0;
        step(32'h0);
        chk("n_next_rd1", n_rd1, 32'hDEADBEEF);

        for (int i = 0; i < 10; i++) begin
            instr = vecs[i].instr; src = vecs[i].src; d_valid = vecs[i].valid;
            pc = 32'h1000 + 32'(4 * i);
            step(vecs[i].imm);
        end

        // Multi-cycle stall with a writeback to the held rs2.
        src = 0; d_valid = 1; instr = mk_r(5'd3, 5'd7, 5'd9); pc = 32'h200;
        step(32'd7);
        stall = 1; instr = mk_r(5'd1, 5'd1, 5'd1); pc = 32'h999;
        step(32'h0);
        we = 1; waddr = 5'd7; wdata = 32'h1234;
        step(32'h0);
        chk("stall_rd2", b_rd2, 32'h1234);
        chk("stall_n_rd2", n_rd2, 32'h1234);
        chk("stall_pc_held", b_pc, 32'h200);
        we = 0;
        step(32'h0);

        // Both operands name x9; a stalled write to x0 must not touch rs1=x0 later.
        stall = 0; instr = mk_r(5'd9, 5'd9, 5'd1);
        step(32'd9);
        stall = 1; we = 1; waddr = 5'd9; wdata = 32'h99;
        step(32'h0);
        chk("dual_rd1", b_rd1, 32'h99);
        chk("dual_rd2", b_rd2, 32'h99);
        stall = 0; we = 0; instr = mk_r(5'd0, 5'd9, 5'd1);
        step(32'd9);
        stall = 1; we = 1; waddr = 5'd0; wdata = 32'hFFFF;
        step(32'h0);
        chk("x0_refresh", b_rd1, 0);

        // Flush beats stall.
        we = 0; flush = 1;
        step(32'h0);
        chk("flush_n_valid", n_valid, 0);
        chk("flush_w_pc", w_pc, 0);

        // Reset during an in-flight write.
        flush = 0; stall = 0; we = 1; waddr = 5'd11; wdata = 32'h5555;
        hit_reset();
        we = 0; instr = mk_r(5'd5, 5'd11, 5'd1); d_valid = 1;
        step(32'd11);
        chk("post_rst_n_rd1", n_rd1, 0);
        chk("post_rst_n_rd2", n_rd2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
